// File: rtl/intr_arbiter.sv
// intr_arbiter: four-source interrupt controller with IO-mapped IER/IPR/MODE/ACT
// registers, fixed priority (bit 0 highest), non-pre-emptive single grant.
module intr_arbiter #(
   parameter logic [15:0] BASE_ADDR = 16'h1010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] io_addr,
   input  logic [7:0]  io_din,
   input  logic        io_we,
   input  logic        io_re,
   output logic [7:0]  io_dout,
   output logic        io_hit,
   input  logic [3:0]  src,
   output logic [3:0]  irq,
   input  logic [3:0]  irq_clr
);

   localparam int unsigned N_SRC = 4;
   localparam int unsigned GW    = 2;
   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 8;

   localparam logic [GW-1:0] OFF_IER  = GW'(0);
   localparam logic [GW-1:0] OFF_IPR  = GW'(1);
   localparam logic [GW-1:0] OFF_MODE = GW'(2);
   localparam logic [GW-1:0] OFF_ACT  = GW'(3);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state;
   logic [N_SRC-1:0] ier;
   logic [N_SRC-1:0] mode;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] src_q;
   logic [GW-1:0]    grant;

   logic [AW-1:0]    offset;
   logic [GW-1:0]    sel;
   logic             wr_ier;
   logic             wr_ipr;
   logic             wr_mode;
   logic [N_SRC-1:0] wdata;

   logic [N_SRC-1:0] grant_onehot;
   logic [N_SRC-1:0] ack_vec;
   logic [N_SRC-1:0] w1c_vec;
   logic [N_SRC-1:0] edge_set;
   logic [N_SRC-1:0] pending_edge;
   logic [N_SRC-1:0] pending_next;
   logic [N_SRC-1:0] eligible;
   logic [GW-1:0]    pick_idx;
   logic             release_grant;
   logic             unused_din;

   // Address decode: a window of four bytes starting at BASE_ADDR
   assign offset  = io_addr - BASE_ADDR;
   assign io_hit  = (offset[AW-1:GW] == '0);
   assign sel     = offset[GW-1:0];
   assign wr_ier  = io_we & io_hit & (sel == OFF_IER);
   assign wr_ipr  = io_we & io_hit & (sel == OFF_IPR);
   assign wr_mode = io_we & io_hit & (sel == OFF_MODE);
   assign wdata   = io_din[N_SRC-1:0];

   // Only the low nibble of write data carries register bits
   assign unused_din = ^io_din[DW-1:N_SRC];

   // Pending-bit next value: level bits follow src, edge bits set on rise / clear on W1C or ack
   always_comb begin
      grant_onehot = N_SRC'(1) << grant;
      ack_vec      = (state == GRANT) ? (irq_clr & grant_onehot) : '0;
      w1c_vec      = wr_ipr ? wdata : '0;
      edge_set     = src & ~src_q;
      pending_edge = edge_set | (pending & ~(w1c_vec | ack_vec));
      pending_next = (mode & src) | (~mode & pending_edge);
   end

   // Fixed-priority pick among enabled pending sources, lowest index wins
   always_comb begin
      eligible = pending & ier;
      pick_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            pick_idx = GW'(i);
         end
      end
   end

   // Conditions that end the current grant
   always_comb begin
      release_grant = 1'b0;
      if (irq_clr[grant]) begin
         release_grant = 1'b1;
      end
      if (wr_ier && !io_din[grant]) begin
         release_grant = 1'b1;
      end
      if (wr_ipr && io_din[grant] && !mode[grant]) begin
         release_grant = 1'b1;
      end
      if (mode[grant] && !pending[grant]) begin
         release_grant = 1'b1;
      end
   end

   // Control registers, src sampling and pending bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ier     <= '0;
         mode    <= '0;
         pending <= '0;
         src_q   <= '0;
      end else begin
         src_q   <= src;
         pending <= pending_next;
         if (wr_ier) begin
            ier <= wdata;
         end
         if (wr_mode) begin
            mode <= wdata;
         end
      end
   end

   // Grant FSM with registered irq; a release always passes through IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         grant <= '0;
         irq   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (eligible != '0) begin
                  state <= GRANT;
                  grant <= pick_idx;
                  irq   <= N_SRC'(1) << pick_idx;
               end else begin
                  irq   <= '0;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  state <= IDLE;
                  irq   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               irq   <= '0;
            end
         endcase
      end
   end

   // Combinational read mux, zero when not selected
   always_comb begin
      io_dout = '0;
      if (io_re && io_hit) begin
         case (sel)
            OFF_IER:  io_dout = DW'(ier);
            OFF_IPR:  io_dout = DW'(pending);
            OFF_MODE: io_dout = DW'(mode);
            OFF_ACT:  io_dout = (state == GRANT) ? {1'b1, 5'b0, grant} : '0;
            default:  io_dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the interrupt controller.
module tb_intr_arbiter;

   localparam logic [15:0] BASE = 16'h1010;

   logic        clk;
   logic        reset;
   logic [15:0] io_addr;
   logic [7:0]  io_din;
   logic        io_we;
   logic        io_re;
   logic [7:0]  io_dout;
   logic        io_hit;
   logic [3:0]  src;
   logic [3:0]  irq;
   logic [3:0]  irq_clr;

   int checks;
   int failures;

   // behavioural model state
   logic [3:0] m_ier, m_mode, m_pend, m_srcq;
   bit         m_busy;
   int         m_gnt;
   logic [3:0] n_ier, n_mode, n_pend, n_srcq;
   bit         n_busy;
   int         n_gnt;

   intr_arbiter #(.BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .io_addr (io_addr),
      .io_din  (io_din),
      .io_we   (io_we),
      .io_re   (io_re),
      .io_dout (io_dout),
      .io_hit  (io_hit),
      .src     (src),
      .irq     (irq),
      .irq_clr (irq_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_ier  = '0;
      m_mode = '0;
      m_pend = '0;
      m_srcq = '0;
      m_busy = 0;
      m_gnt  = 0;
   endtask

   function automatic logic [3:0] model_irq();
      return m_busy ? 4'(1 << m_gnt) : 4'b0000;
   endfunction

   function automatic logic [7:0] model_reg(input int off);
      case (off)
         0: return {4'b0, m_ier};
         1: return {4'b0, m_pend};
         2: return {4'b0, m_mode};
         3: return m_busy ? {1'b1, 5'b0, 2'(m_gnt)} : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   // next model state from the rules, given the inputs present before the edge
   task automatic model_next();
      int off;
      bit wr;
      bit rel;
      bit set_b;
      bit clr_b;
      off = int'(io_addr) - int'(BASE);
      wr  = io_we && (off >= 0) && (off <= 3);
      for (int i = 0; i < 4; i++) begin
         if (m_mode[i]) begin
            n_pend[i] = src[i];
         end else begin
            set_b = src[i] && !m_srcq[i];
            clr_b = (wr && off == 1 && io_din[i]) || (m_busy && m_gnt == i && irq_clr[i]);
            n_pend[i] = set_b || (m_pend[i] && !clr_b);
         end
      end
      n_ier  = (wr && off == 0) ? io_din[3:0] : m_ier;
      n_mode = (wr && off == 2) ? io_din[3:0] : m_mode;
      n_srcq = src;
      n_gnt  = m_gnt;
      if (!m_busy) begin
         n_busy = 0;
         for (int i = 0; i < 4; i++) begin
            if (!n_busy && m_pend[i] && m_ier[i]) begin
               n_busy = 1;
               n_gnt  = i;
            end
         end
      end else begin
         rel = irq_clr[m_gnt]
            || (wr && off == 0 && !io_din[m_gnt])
            || (wr && off == 1 && io_din[m_gnt] && !m_mode[m_gnt])
            || (m_mode[m_gnt] && !m_pend[m_gnt]);
         n_busy = !rel;
      end
   endtask

   // advance one clock edge, keeping the model in lockstep; returns 1ns after the edge
   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      m_ier  = n_ier;
      m_mode = n_mode;
      m_pend = n_pend;
      m_srcq = n_srcq;
      m_busy = n_busy;
      m_gnt  = n_gnt;
   endtask

   task automatic bus_write(input int off, input logic [7:0] d);
      io_addr = 16'(int'(BASE) + off);
      io_din  = d;
      io_we   = 1'b1;
      step();
      io_we   = 1'b0;
      io_din  = 8'h00;
   endtask

   task automatic bus_read(input int off, output logic [7:0] d);
      io_addr = 16'(int'(BASE) + off);
      io_re   = 1'b1;
      #1;
      d       = io_dout;
      io_re   = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (irq !== 4'b0000) begin
         failures++;
         $display("FAIL reset_irq got=%b exp=0000", irq);
      end
      for (int k = 0; k < 4; k++) begin
         bus_read(k, d);
         checks++;
         if (d !== 8'h00) begin
            failures++;
            $display("FAIL reset_reg%0d got=%h exp=00", k, d);
         end
      end
      io_addr = BASE + 16'd4;
      io_re   = 1'b1;
      #1;
      checks++;
      if (io_hit !== 1'b0 || io_dout !== 8'h00) begin
         failures++;
         $display("FAIL hit_above got_hit=%b got_dout=%h exp=0/00", io_hit, io_dout);
      end
      io_addr = BASE - 16'd1;
      #1;
      checks++;
      if (io_hit !== 1'b0) begin
         failures++;
         $display("FAIL hit_below got=%b exp=0", io_hit);
      end
      io_addr = BASE + 16'd3;
      io_re   = 1'b0;
      #0.5;
      checks++;
      if (io_hit !== 1'b1 || io_dout !== 8'h00) begin
         failures++;
         $display("FAIL hit_top_noread got_hit=%b got_dout=%h exp=1/00", io_hit, io_dout);
      end
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_registers();
      logic [7:0] d;
      bus_write(0, 8'hA5);
      bus_read(0, d);
      checks++;
      if (d !== 8'h05) begin
         failures++;
         $display("FAIL ier_rw got=%h exp=05", d);
      end
      bus_write(2, 8'hF6);
      bus_read(2, d);
      checks++;
      if (d !== 8'h06) begin
         failures++;
         $display("FAIL mode_rw got=%h exp=06", d);
      end
      bus_write(3, 8'hFF);
      bus_read(3, d);
      checks++;
      if (d !== 8'h00) begin
         failures++;
         $display("FAIL act_ro got=%h exp=00", d);
      end
      bus_write(0, 8'h00);
      bus_write(2, 8'h00);
   endtask

   task automatic test_single_pulse();
      logic [7:0] d;
      bus_write(0, 8'h0F);
      bus_write(2, 8'h00);
      repeat (3) step();
      src = 4'b0100;
      step();
      src = 4'b0000;
      bus_read(1, d);
      checks++;
      if (d !== 8'h04 || irq !== 4'b0000) begin
         failures++;
         $display("FAIL pulse_pending got_ipr=%h got_irq=%b exp=04/0000", d, irq);
      end
      step();
      checks++;
      if (irq !== 4'b0100) begin
         failures++;
         $display("FAIL pulse_irq got=%b exp=0100", irq);
      end
      bus_read(3, d);
      checks++;
      if (d !== 8'h82) begin
         failures++;
         $display("FAIL pulse_act got=%h exp=82", d);
      end
      repeat (3) step();
      checks++;
      if (irq !== 4'b0100) begin
         failures++;
         $display("FAIL pulse_hold got=%b exp=0100", irq);
      end
      irq_clr = 4'b1011;
      step();
      checks++;
      if (irq !== 4'b0100) begin
         failures++;
         $display("FAIL clr_other_ignored got=%b exp=0100", irq);
      end
      irq_clr = 4'b0100;
      step();
      irq_clr = 4'b0000;
      bus_read(1, d);
      checks++;
      if (irq !== 4'b0000 || d !== 8'h00) begin
         failures++;
         $display("FAIL pulse_release got_irq=%b got_ipr=%h exp=0000/00", irq, d);
      end
   endtask

   task automatic test_priority();
      src = 4'b1010;
      step();
      src = 4'b0000;
      step();
      checks++;
      if (irq !== 4'b0010) begin
         failures++;
         $display("FAIL prio_first got=%b exp=0010", irq);
      end
      irq_clr = 4'b0010;
      step();
      irq_clr = 4'b0000;
      checks++;
      if (irq !== 4'b0000) begin
         failures++;
         $display("FAIL prio_idle_gap got=%b exp=0000", irq);
      end
      step();
      checks++;
      if (irq !== 4'b1000) begin
         failures++;
         $display("FAIL prio_second got=%b exp=1000", irq);
      end
      irq_clr = 4'b1000;
      step();
      irq_clr = 4'b0000;
   endtask

   task automatic test_no_preempt();
      logic [7:0] d;
      src = 4'b1000;
      step();
      src = 4'b0000;
      step();
      src = 4'b0001;
      step();
      src = 4'b0000;
      bus_read(1, d);
      checks++;
      if (irq !== 4'b1000 || d !== 8'h09) begin
         failures++;
         $display("FAIL no_preempt got_irq=%b got_ipr=%h exp=1000/09", irq, d);
      end
      irq_clr = 4'b1000;
      step();
      irq_clr = 4'b0000;
      step();
      checks++;
      if (irq !== 4'b0001) begin
         failures++;
         $display("FAIL preempt_next got=%b exp=0001", irq);
      end
      irq_clr = 4'b0001;
      step();
      irq_clr = 4'b0000;
   endtask

   task automatic test_ier_gate();
      logic [7:0] d;
      bus_write(0, 8'h00);
      src = 4'b0010;
      step();
      src = 4'b0000;
      step();
      bus_read(1, d);
      checks++;
      if (d !== 8'h02 || irq !== 4'b0000) begin
         failures++;
         $display("FAIL gated_pending got_ipr=%h got_irq=%b exp=02/0000", d, irq);
      end
      bus_write(0, 8'h02);
      checks++;
      if (irq !== 4'b0000) begin
         failures++;
         $display("FAIL enable_lat1 got=%b exp=0000", irq);
      end
      step();
      checks++;
      if (irq !== 4'b0010) begin
         failures++;
         $display("FAIL enable_lat2 got=%b exp=0010", irq);
      end
      bus_write(0, 8'h00);
      bus_read(1, d);
      checks++;
      if (irq !== 4'b0000 || d !== 8'h02) begin
         failures++;
         $display("FAIL disable_release got_irq=%b got_ipr=%h exp=0000/02", irq, d);
      end
      bus_write(1, 8'h02);
   endtask

   task automatic test_level_mode();
      bus_write(2, 8'h01);
      bus_write(0, 8'h01);
      src = 4'b0001;
      step();
      step();
      checks++;
      if (irq !== 4'b0001) begin
         failures++;
         $display("FAIL level_grant got=%b exp=0001", irq);
      end
      irq_clr = 4'b0001;
      step();
      irq_clr = 4'b0000;
      checks++;
      if (irq !== 4'b0000) begin
         failures++;
         $display("FAIL level_ack_gap got=%b exp=0000", irq);
      end
      step();
      checks++;
      if (irq !== 4'b0001) begin
         failures++;
         $display("FAIL level_regrant got=%b exp=0001", irq);
      end
      src = 4'b0000;
      repeat (2) step();
      checks++;
      if (irq !== 4'b0000) begin
         failures++;
         $display("FAIL level_drop got=%b exp=0000", irq);
      end
      bus_write(2, 8'h00);
   endtask

   task automatic test_reset_mid_grant();
      logic [7:0] d;
      bus_write(0, 8'h0F);
      src = 4'b0100;
      step();
      src = 4'b0001;
      step();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (irq !== 4'b0000) begin
         failures++;
         $display("FAIL async_reset_irq got=%b exp=0000", irq);
      end
      model_reset();
      src = 4'b0001;
      #1;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_read(k, d);
         checks++;
         if (d !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_reg%0d got=%h exp=00", k, d);
         end
      end
      step();
      bus_read(1, d);
      checks++;
      if (d !== 8'h01) begin
         failures++;
         $display("FAIL first_edge_after_reset got=%h exp=01", d);
      end
      src = 4'b0000;
      bus_write(1, 8'h0F);
   endtask

   task automatic test_random();
      int off;
      for (int c = 0; c < 2000; c++) begin
         src = 4'($urandom & $urandom & $urandom);
         case ($urandom_range(0, 3))
            0: irq_clr = 4'(1 << m_gnt);
            1: irq_clr = 4'($urandom);
            default: irq_clr = 4'b0000;
         endcase
         off     = $urandom_range(0, 5) - 1;
         io_addr = 16'(int'(BASE) + off);
         io_din  = 8'($urandom);
         io_we   = ($urandom_range(0, 5) == 0);
         io_re   = ($urandom_range(0, 1) == 1);
         #1;
         checks++;
         if (io_dout !== ((io_re && off >= 0 && off <= 3) ? model_reg(off) : 8'h00)
             || io_hit !== (off >= 0 && off <= 3)) begin
            failures++;
            $display("FAIL rand_read cyc=%0d off=%0d got_dout=%h got_hit=%b exp_dout=%h",
                     c, off, io_dout, io_hit, (io_re && off >= 0 && off <= 3) ? model_reg(off) : 8'h00);
         end
         step();
         checks++;
         if (irq !== model_irq()) begin
            failures++;
            $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, irq, model_irq());
         end
      end
      src     = 4'b0000;
      irq_clr = 4'b0000;
      io_we   = 1'b0;
      io_re   = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      io_addr  = 16'h0000;
      io_din   = 8'h00;
      io_we    = 1'b0;
      io_re    = 1'b0;
      src      = 4'b0000;
      irq_clr  = 4'b0000;
      model_reset();
      test_reset();
      test_registers();
      test_single_pulse();
      test_priority();
      test_no_preempt();
      test_ier_gate();
      test_level_mode();
      test_reset_mid_grant();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intr_arbiter.md
INTR_ARBITER -- requirements
Module: intr_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 16'h1010, SHALL be the IO address of register 0; registers occupy BASE_ADDR+0..+3.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 io_addr  input  16  CPU data/IO bus address.
REQ-005 io_din  input  8  CPU write data.
REQ-006 io_we  input  1  write strobe, one cycle per write.
REQ-007 io_re  input  1  read strobe.
REQ-008 io_dout  output  8  read data; 8'h00 when not selected.
REQ-009 io_hit  output  1  high when io_addr is within BASE_ADDR..BASE_ADDR+3; used by the SoC read-data mux.
REQ-010 src  input  4  peripheral requests, synchronous to clk; bit 0 is highest priority.
REQ-011 irq  output  4  one-hot-or-zero interrupt lines to CPU interrupt_0..3.
REQ-012 irq_clr  input  4  acknowledge from CPU interrupt_0_clr..3_clr.

Function
REQ-013 Registers SHALL be: +0 IER (RW, 4-bit enable mask), +1 IPR (R pending; write-1-to-clear), +2 MODE (RW; bit=0 rising-edge, bit=1 level-high), +3 ACT (RO: bit 7 = grant valid, bits 1:0 = granted index); bits 7:4 of IER/IPR/MODE SHALL read 0.
REQ-014 Register writes SHALL take effect on the clk edge where io_we=1 and io_hit=1; writes to ACT SHALL be ignored.
REQ-015 io_dout SHALL be combinational: selected register when io_re=1 and io_hit=1, else 8'h00.
REQ-016 src SHALL be registered once (src_q); edge mode: pending[i] SHALL set on the edge where src[i]=1 and src_q[i]=0.
REQ-017 Level mode: pending[i] SHALL load src[i] every cycle; IPR write-1-to-clear and irq_clr SHALL not affect level-mode bits.
REQ-018 Edge mode: pending[i] SHALL clear on IPR write-1 to bit i or on irq_clr[i] while i is granted; a simultaneous set SHALL win (bit stays 1).
REQ-019 Pending SHALL be recorded regardless of IER; IER gates only arbitration.
REQ-020 FSM states SHALL be IDLE and GRANT.
REQ-021 IDLE: if (pending & IER) != 0, SHALL latch the lowest set index as grant and enter GRANT on the next edge; else stay IDLE.
REQ-022 irq SHALL be registered: irq[grant]=1 exactly while in GRANT, all other bits 0; latency from src edge to irq high = 2 cycles.
REQ-023 GRANT: higher-priority sources arriving later SHALL NOT pre-empt; grant holds until release.
REQ-024 Release from GRANT to IDLE SHALL occur on the edge where irq_clr[grant]=1, or IER[grant] is written 0, or IPR bit grant is written 1 (edge mode), or pending[grant]=0 (level mode source dropped).
REQ-025 irq_clr bits other than the granted index SHALL be ignored; irq_clr in IDLE SHALL be ignored.
REQ-026 After release the FSM SHALL spend at least one cycle in IDLE (irq all 0) before a new grant.
REQ-027 On release by IER write, pending[grant] SHALL be retained.

Reset
REQ-028 reset=0 SHALL asynchronously set IER=0, IPR=0, MODE=0, src_q=0, state=IDLE, grant=0, irq=4'b0000.
REQ-029 A reset during GRANT SHALL drop irq the same instant and discard the grant and all pending bits.
REQ-030 First pending set after reset release SHALL require a 0->1 transition of src relative to src_q=0.

Verification
REQ-031 IER=4'hF, MODE=0; pulse src[2] one cycle at cycle 10 -> IPR=4'b0100 at 11, irq=4'b0100 at 12, held until irq_clr[2]; next edge irq=0, IPR=0.
REQ-032 IER=4'hF; src[3] and src[1] rise same cycle -> irq=4'b0010; after irq_clr[1], one idle cycle, then irq=4'b1000.
REQ-033 In GRANT on index 3, src[0] rises -> irq stays 4'b1000, IPR=4'b1001; after irq_clr[3] grant goes to 0.
REQ-034 IER=0, pulse src[1] -> IPR=4'b0010, irq=0; write IER=4'h2 -> irq=4'b0010 two cycles after write; write IER=0 -> irq=0, IPR still 4'b0010.
REQ-035 MODE[0]=1, IER[0]=1; hold src[0]=1 -> irq=4'b0001 persists across irq_clr[0] re-grant; drop src[0] -> irq=0 within 2 cycles.
REQ-036 Assert reset=0 mid-GRANT between clk edges -> irq=0 immediately; read IER/IPR/MODE/ACT after release -> all 8'h00.
